// File: rtl/datapath_sequencer_if.sv
// Instruction handshake bundle between the instruction source and datapath_sequencer.
interface datapath_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr;
  logic                  instr_ready;

  modport master (output instr_valid, output instr, input instr_ready);
  modport slave  (input instr_valid, input instr, output instr_ready);
endinterface

// File: rtl/datapath_sequencer.sv
// Four-state RV32 subset sequencer (addi/add/bne) driving register-file and ALU controls.
// Optional retired-instruction counter enabled by defining SEQ_PERF_CNT_EN.
module datapath_sequencer #(
  parameter int unsigned           DATA_WIDTH    = 32,
  parameter int unsigned           ADDRESS_WIDTH = 5,
  parameter logic [DATA_WIDTH-1:0] PC_RESET      = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  datapath_sequencer_if.slave      ibus,
  input  logic                     EQ,
  output logic [ADDRESS_WIDTH-1:0] AD1,
  output logic [ADDRESS_WIDTH-1:0] AD2,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    ImmOp,
  output logic                     RegWrite,
  output logic                     ALUctrl,
  output logic                     ALUsrc,
  output logic [DATA_WIDTH-1:0]    pc,
  output logic                     err
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [DATA_WIDTH-1:0]    retired_cnt
`endif
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EXEC   = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  logic [1:0]               r_state;
  logic [DATA_WIDTH-1:0]    r_instr;
  logic [ADDRESS_WIDTH-1:0] r_ad1;
  logic [ADDRESS_WIDTH-1:0] r_ad2;
  logic [ADDRESS_WIDTH-1:0] r_ad3;
  logic [DATA_WIDTH-1:0]    r_imm;
  logic                     r_regwrite;
  logic                     r_aluctrl;
  logic                     r_alusrc;
  logic [DATA_WIDTH-1:0]    r_pc;
  logic                     r_err;

  logic [6:0]               w_opcode;
  logic [2:0]               w_funct3;
  logic [6:0]               w_funct7;
  logic                     w_is_addi;
  logic                     w_is_add;
  logic                     w_is_bne;
  logic                     w_legal;
  logic [DATA_WIDTH-1:0]    w_imm_i;
  logic [DATA_WIDTH-1:0]    w_imm_b;
  logic [DATA_WIDTH-1:0]    w_dec_imm;
  logic [ADDRESS_WIDTH-1:0] w_dec_ad3;
  logic                     w_dec_wr;
  logic [DATA_WIDTH-1:0]    w_pc_next;

  assign w_opcode  = r_instr[6:0];
  assign w_funct3  = r_instr[14:12];
  assign w_funct7  = r_instr[31:25];
  assign w_is_addi = (w_opcode == 7'b0010011) && (w_funct3 == 3'b000);
  assign w_is_add  = (w_opcode == 7'b0110011) && (w_funct3 == 3'b000) && (w_funct7 == 7'b0000000);
  assign w_is_bne  = (w_opcode == 7'b1100011) && (w_funct3 == 3'b001);
  assign w_legal   = w_is_addi || w_is_add || w_is_bne;

  assign w_imm_i = {{(DATA_WIDTH-12){r_instr[31]}}, r_instr[31:20]};
  assign w_imm_b = {{(DATA_WIDTH-13){r_instr[31]}}, r_instr[31], r_instr[7],
                    r_instr[30:25], r_instr[11:8], 1'b0};

  always_comb begin
    w_dec_imm = '0;
    w_dec_ad3 = ADDRESS_WIDTH'(r_instr[11:7]);
    if (w_is_addi) begin
      w_dec_imm = w_imm_i;
    end else if (w_is_bne) begin
      w_dec_imm = w_imm_b;
      w_dec_ad3 = '0;
    end
  end

  // Writes to x0 are suppressed here so EXEC only ever sees a meaningful pulse.
  assign w_dec_wr = (w_is_addi || w_is_add) && (r_instr[11:7] != 5'd0);

  // ALUctrl is set only for bne, so it doubles as the branch flag in EXEC.
  assign w_pc_next = (r_aluctrl && !EQ) ? (r_pc + r_imm) : (r_pc + PC_STEP);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_instr    <= '0;
      r_ad1      <= '0;
      r_ad2      <= '0;
      r_ad3      <= '0;
      r_imm      <= '0;
      r_regwrite <= 1'b0;
      r_aluctrl  <= 1'b0;
      r_alusrc   <= 1'b0;
      r_pc       <= PC_RESET;
      r_err      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (ibus.instr_valid) begin
            r_instr <= ibus.instr;
            r_state <= DECODE;
          end
        end
        DECODE: begin
          if (w_legal) begin
            r_ad1      <= ADDRESS_WIDTH'(r_instr[19:15]);
            r_ad2      <= ADDRESS_WIDTH'(r_instr[24:20]);
            r_ad3      <= w_dec_ad3;
            r_imm      <= w_dec_imm;
            r_alusrc   <= w_is_addi;
            r_aluctrl  <= w_is_bne;
            r_regwrite <= w_dec_wr;
            r_state    <= EXEC;
          end else begin
            r_err   <= 1'b1;
            r_state <= ERROR;
          end
        end
        EXEC: begin
          r_regwrite <= 1'b0;
          r_pc       <= w_pc_next;
          r_state    <= IDLE;
        end
        default: begin
          r_err   <= 1'b1;
          r_state <= ERROR;
        end
      endcase
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [DATA_WIDTH-1:0] r_retired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (r_state == EXEC) begin
      r_retired <= r_retired + DATA_WIDTH'(1);
    end
  end

  assign retired_cnt = r_retired;
`endif

  assign ibus.instr_ready = (r_state == IDLE);
  assign AD1      = r_ad1;
  assign AD2      = r_ad2;
  assign AD3      = r_ad3;
  assign ImmOp    = r_imm;
  assign RegWrite = r_regwrite;
  assign ALUctrl  = r_aluctrl;
  assign ALUsrc   = r_alusrc;
  assign pc       = r_pc;
  assign err      = r_err;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Self-checking bench for datapath_sequencer: directed vector table, reset corner cases,
// and randomized instruction streams checked against an instruction-level model.
module tb_datapath_sequencer;

  localparam logic [31:0] PC_RST = 32'h0;

  logic        clk;
  logic        rst_n;
  logic        EQ;
  logic [4:0]  AD1, AD2, AD3;
  logic [31:0] ImmOp;
  logic        RegWrite, ALUctrl, ALUsrc;
  logic [31:0] pc;
  logic        err;
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  datapath_sequencer_if #(.DATA_WIDTH(32)) bus ();

  datapath_sequencer #(
    .DATA_WIDTH   (32),
    .ADDRESS_WIDTH(5),
    .PC_RESET     (PC_RST)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .ibus    (bus),
    .EQ      (EQ),
    .AD1     (AD1),
    .AD2     (AD2),
    .AD3     (AD3),
    .ImmOp   (ImmOp),
    .RegWrite(RegWrite),
    .ALUctrl (ALUctrl),
    .ALUsrc  (ALUsrc),
    .pc      (pc),
    .err     (err)
`ifdef SEQ_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  typedef struct {
    logic [31:0] ins;
    logic        eq;
    logic        legal;
    logic [4:0]  ad1;
    logic [4:0]  ad2;
    logic [4:0]  ad3;
    logic [31:0] imm;
    logic        src;
    logic        ctrl;
    logic        rw;
    logic [31:0] pc_next;
  } vec_t;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [31:0] m_pc;
  logic [31:0] m_retired;
  vec_t        vecs [9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Instruction-level reference: fields by shifting, immediates by signed arithmetic.
  function automatic vec_t model(input logic [31:0] ins, input logic eq, input logic [31:0] cur_pc);
    vec_t        v;
    logic [31:0] op, f3, f7;
    int          s, boff;
    op = ins & 32'h7F;
    f3 = (ins >> 12) & 32'd7;
    f7 = ins >> 25;
    v.ins     = ins;
    v.eq      = eq;
    v.legal   = 1'b1;
    v.ad1     = 5'(ins >> 15);
    v.ad2     = 5'(ins >> 20);
    v.ad3     = 5'(ins >> 7);
    v.imm     = 32'd0;
    v.src     = 1'b0;
    v.ctrl    = 1'b0;
    v.rw      = 1'b0;
    v.pc_next = cur_pc + 32'd4;
    s = int'(ins);
    if (op == 32'd19 && f3 == 32'd0) begin
      v.imm = 32'(s >>> 20);
      v.src = 1'b1;
      v.rw  = (v.ad3 != 5'd0);
    end else if (op == 32'd51 && f3 == 32'd0 && f7 == 32'd0) begin
      v.rw = (v.ad3 != 5'd0);
    end else if (op == 32'd99 && f3 == 32'd1) begin
      boff = int'(((ins >> 8) & 32'd15) * 32'd2 + ((ins >> 25) & 32'd63) * 32'd32
                  + ((ins >> 7) & 32'd1) * 32'd2048) - int'(((ins >> 31) & 32'd1) * 32'd4096);
      v.imm  = 32'(boff);
      v.ctrl = 1'b1;
      v.ad3  = 5'd0;
      if (!eq) v.pc_next = cur_pc + 32'(boff);
    end else begin
      v.legal   = 1'b0;
      v.pc_next = cur_pc;
    end
    return v;
  endfunction

  function automatic logic [31:0] rand_legal();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 2))
      0:       return {r[31:20], r[19:15], 3'b000, r[11:7], 7'b0010011};
      1:       return {7'b0000000, r[24:20], r[19:15], 3'b000, r[11:7], 7'b0110011};
      default: return {r[31:25], r[24:20], r[19:15], 3'b001, r[11:7], 7'b1100011};
    endcase
  endfunction

  function automatic logic [31:0] rand_illegal();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 3))
      0:       return {7'b0100000, r[24:15], 3'b000, r[11:7], 7'b0110011};
      1:       return {r[31:15], 3'b001, r[11:7], 7'b0010011};
      2:       return {r[31:15], 3'b000, r[11:7], 7'b1100011};
      default: return {r[31:7], 7'b1111111};
    endcase
  endfunction

  // Asserts reset asynchronously, checks the forced values before any clock edge,
  // and releases on a falling edge so the next rising edge may accept.
  task automatic do_reset();
    rst_n = 1'b0;
    bus.instr_valid = 1'b0;
    #1;
    chk("rst_pc", pc, PC_RST);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_regwrite", 32'(RegWrite), 32'd0);
    chk("rst_aluctrl", 32'(ALUctrl), 32'd0);
    chk("rst_alusrc", 32'(ALUsrc), 32'd0);
    chk("rst_ad1", 32'(AD1), 32'd0);
    chk("rst_ad2", 32'(AD2), 32'd0);
    chk("rst_ad3", 32'(AD3), 32'd0);
    chk("rst_immop", ImmOp, 32'd0);
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
`ifdef SEQ_PERF_CNT_EN
    chk("rst_retired", retired_cnt, 32'd0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_pc      = PC_RST;
    m_retired = 32'd0;
  endtask

  // Called on a falling edge while IDLE; returns on the falling edge of cycle N+3.
  task automatic apply(input vec_t v);
    chk("ready_idle", 32'(bus.instr_ready), 32'd1);
    bus.instr_valid = 1'b1;
    bus.instr       = v.ins;
    EQ              = v.eq;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'($urandom_range(0, 1));
    bus.instr       = $urandom;
    @(negedge clk);
    chk("ready_decode", 32'(bus.instr_ready), 32'd0);
    chk("rw_decode", 32'(RegWrite), 32'd0);
    @(negedge clk);
    chk("ready_exec", 32'(bus.instr_ready), 32'd0);
    chk("rw_exec", 32'(RegWrite), 32'(v.rw));
    if (v.legal) begin
      chk("ad1", 32'(AD1), 32'(v.ad1));
      chk("ad2", 32'(AD2), 32'(v.ad2));
      chk("ad3", 32'(AD3), 32'(v.ad3));
      chk("immop", ImmOp, v.imm);
      chk("alusrc", 32'(ALUsrc), 32'(v.src));
      chk("aluctrl", 32'(ALUctrl), 32'(v.ctrl));
      chk("err_exec", 32'(err), 32'd0);
    end else begin
      chk("err_set", 32'(err), 32'd1);
    end
    @(negedge clk);
    bus.instr_valid = 1'b0;
    chk("pc_next", pc, v.pc_next);
    chk("rw_after", 32'(RegWrite), 32'd0);
    chk("ready_after", 32'(bus.instr_ready), 32'(v.legal));
    chk("err_after", 32'(err), 32'(!v.legal));
    m_pc = v.pc_next;
    if (v.legal) m_retired = m_retired + 32'd1;
`ifdef SEQ_PERF_CNT_EN
    chk("retired", retired_cnt, m_retired);
`endif
  endtask

  initial begin
    rst_n           = 1'b1;
    EQ              = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr       = '0;
    m_pc            = PC_RST;
    m_retired       = 32'd0;

    vecs[0] = '{32'h00500513, 1'b0, 1'b1, 5'd0,  5'd0,  5'd10, 32'd5,        1'b1, 1'b0, 1'b1, 32'd4};
    vecs[1] = '{32'h00B50533, 1'b0, 1'b1, 5'd10, 5'd11, 5'd10, 32'd0,        1'b0, 1'b0, 1'b1, 32'd8};
    vecs[2] = '{32'hFE051EE3, 1'b0, 1'b1, 5'd10, 5'd0,  5'd0,  32'hFFFFFFFC, 1'b0, 1'b1, 1'b0, 32'd4};
    vecs[3] = '{32'h00100013, 1'b0, 1'b1, 5'd0,  5'd1,  5'd0,  32'd1,        1'b1, 1'b0, 1'b0, 32'd8};
    vecs[4] = '{32'hFE051EE3, 1'b1, 1'b1, 5'd10, 5'd0,  5'd0,  32'hFFFFFFFC, 1'b0, 1'b1, 1'b0, 32'd12};
    vecs[5] = '{32'h00419463, 1'b0, 1'b1, 5'd3,  5'd4,  5'd0,  32'd8,        1'b0, 1'b1, 1'b0, 32'd20};
    vecs[6] = '{32'h00208033, 1'b1, 1'b1, 5'd1,  5'd2,  5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 32'd24};
    vecs[7] = '{32'hFFF08F93, 1'b0, 1'b1, 5'd1,  5'd31, 5'd31, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b1, 32'd28};
    vecs[8] = '{32'hFFFFFFFF, 1'b0, 1'b0, 5'd0,  5'd0,  5'd0,  32'd0,        1'b0, 1'b0, 1'b0, 32'd28};
    vecs[0].ad2 = 5'd5;

    #2;
    do_reset();

    for (int i = 0; i < 9; i++) apply(vecs[i]);

    // ERROR is terminal: valid traffic is ignored until reset.
    for (int c = 0; c < 6; c++) begin
      bus.instr_valid = 1'b1;
      bus.instr       = $urandom;
      @(negedge clk);
      chk("err_hold", 32'(err), 32'd1);
      chk("err_ready", 32'(bus.instr_ready), 32'd0);
      chk("err_rw", 32'(RegWrite), 32'd0);
      chk("err_pc", pc, 32'd28);
    end
    do_reset();

    // Reset during EXEC kills the RegWrite pulse immediately and restores PC_RESET.
    apply(model(32'h00500513, 1'b0, m_pc));
    bus.instr       = 32'h00500293;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("rw_exec_pre_reset", 32'(RegWrite), 32'd1);
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_reset_rw", 32'(RegWrite), 32'd0);
      chk("post_reset_pc", pc, PC_RST);
    end

    // Reset during DECODE abandons the instruction without a write.
    bus.instr       = 32'h00700313;
    bus.instr_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.instr_valid = 1'b0;
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("post_dreset_rw", 32'(RegWrite), 32'd0);
      chk("post_dreset_ready", 32'(bus.instr_ready), 32'd1);
    end

    for (int i = 0; i < 3; i++) apply(model(rand_legal(), 1'($urandom_range(0, 1)), m_pc));
`ifdef SEQ_PERF_CNT_EN
    chk("retired_three", retired_cnt, 32'd3);
`endif

    // Random streams against the model, each ending in an illegal encoding.
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < 20; i++) apply(model(rand_legal(), 1'($urandom_range(0, 1)), m_pc));
      apply(model(rand_illegal(), 1'b0, m_pc));
    end
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the datapath, instruction, PC and immediate width.
REQ-002 Parameter ADDRESS_WIDTH, default 5, SHALL set the register-address width.
REQ-003 Parameter PC_RESET, default 0, SHALL set the PC value loaded on reset.
REQ-004 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 instr_valid  input  1  SHALL indicate that instr holds an instruction.
REQ-007 instr  input  DATA_WIDTH  SHALL be the RV32 instruction word.
REQ-008 instr_ready  output  1  SHALL indicate that the sequencer accepts an instruction this cycle.
REQ-009 EQ  input  1  SHALL be the ALU equality flag returned from the datapath.
REQ-010 AD1, AD2, AD3  output  ADDRESS_WIDTH each  SHALL drive the rs1, rs2 and rd addresses.
REQ-011 ImmOp  output  DATA_WIDTH  SHALL drive the sign-extended immediate.
REQ-012 RegWrite, ALUctrl, ALUsrc  output  1 each  SHALL drive the write enable, ALU control (0=add, 1=sub/compare) and operand-2 select (1=immediate).
REQ-013 pc  output  DATA_WIDTH  SHALL be the current program counter.
REQ-014 err  output  1  SHALL be the sticky illegal-instruction flag.

Function
REQ-015 FSM states SHALL be IDLE, DECODE, EXEC and ERROR.
REQ-016 instr_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, instr_valid=1 SHALL capture instr into an internal register and move to DECODE; instr_valid=0 SHALL stay in IDLE.
REQ-018 In DECODE, registered AD1=instr[19:15], AD2=instr[24:20], AD3=instr[11:7], ImmOp, ALUsrc and ALUctrl SHALL be set; they SHALL hold through EXEC; the next state SHALL be EXEC.
REQ-019 addi (opcode 0010011, funct3 000): ALUsrc=1, ALUctrl=0, ImmOp=sign-extended instr[31:20].
REQ-020 add (opcode 0110011, funct3 000, funct7 0000000): ALUsrc=0, ALUctrl=0, ImmOp=0.
REQ-021 bne (opcode 1100011, funct3 001): ALUsrc=0, ALUctrl=1, AD3=0, ImmOp=sign-extended {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}.
REQ-022 Any other encoding SHALL move DECODE to ERROR, with RegWrite=0, pc unchanged and err=1.
REQ-023 In EXEC, RegWrite SHALL be 1 for exactly one cycle for addi/add when AD3 is nonzero, and 0 for writes to x0 and for bne.
REQ-024 On leaving EXEC, pc SHALL become pc+4, except for bne with EQ=0, where it SHALL become pc+ImmOp (modulo 2^DATA_WIDTH, wrap-around permitted); the next state SHALL be IDLE.
REQ-025 Latency: instruction accepted at edge N, DECODE in cycle N+1, EXEC in cycle N+2, IDLE with updated pc in cycle N+3; the next accept SHALL occur no earlier than cycle N+3.
REQ-026 ERROR SHALL be terminal: instr_ready=0 and err=1 until reset.
REQ-027 instr_valid changes outside IDLE SHALL be ignored.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, pc=PC_RESET, err=0 and RegWrite=ALUctrl=ALUsrc=0, with AD1=AD2=AD3=0 and ImmOp=0, regardless of clk.
REQ-029 Reset asserted mid-instruction (in DECODE or EXEC) SHALL abandon the instruction with no RegWrite pulse.
REQ-030 After rst_n deasserts, the first accept SHALL occur at the first rising edge with instr_valid=1.

Configuration
REQ-031 With macro SEQ_PERF_CNT_EN defined, output retired_cnt (DATA_WIDTH) SHALL count completed EXEC cycles, reset to 0 and wrap at 2^DATA_WIDTH.
REQ-032 Without SEQ_PERF_CNT_EN, the retired_cnt port and its counter SHALL be absent, with all other behaviour identical.

Verification
REQ-033 Reset, then addi x10,x0,5 (0x00500513) -> AD3=10, ALUsrc=1, ImmOp=5, a single RegWrite pulse in cycle N+2, pc=4.
REQ-034 add x10,x10,x11 (0x00B50533) -> ALUsrc=0, ALUctrl=0, AD1=10, AD2=11, RegWrite pulse, pc+=4.
REQ-035 bne x10,x0,-4 (0xFE051EE3) at pc=8 -> ALUctrl=1, RegWrite=0; EQ=0 gives pc=4; EQ=1 gives pc=12.
REQ-036 addi x0,x0,1 -> RegWrite stays 0 and pc advances by 4; then 0xFFFFFFFF -> err=1 and instr_ready=0 until rst_n pulses low.
REQ-037 rst_n asserted low in EXEC -> RegWrite drops immediately, pc=PC_RESET; with SEQ_PERF_CNT_EN, retired_cnt=0 and counts 3 after three instructions.
